// File: rtl/alu_arb_if.sv
// alu_arb_if: two requester channels and one response slot for the shared ALU
interface alu_arb_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             resp_valid, resp_ready, resp_id, zero, illegal;
  logic [WIDTH-1:0] result;
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, result, zero, illegal
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, result, zero, illegal
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one integer ALU with a registered response slot
module alu_arbiter #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset_n,
  alu_arb_if.slave bus
);
  logic ptr, slot_free, g0, g1, acc, sel, ill;
  logic resp_valid, resp_id, zero, illegal;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, res, result;
  always_comb begin
    slot_free = !resp_valid || bus.resp_ready;
    g0 = bus.req0_valid && (!bus.req1_valid || !ptr);
    g1 = bus.req1_valid && (!bus.req0_valid || ptr);
    acc = slot_free && (g0 || g1);
    sel = g1;
    op = sel ? bus.req1_op : bus.req0_op;
    a = sel ? bus.req1_a : bus.req0_a;
    b = sel ? bus.req1_b : bus.req0_b;
    ill = op == 3'd3;
    res = op == 3'd0 ? a + b :
          op == 3'd1 ? a - b :
          op == 3'd2 ? a & b :
          op == 3'd4 ? a | b :
          op == 3'd5 ? a & ~b :
          op == 3'd6 ? a | ~b :
          op == 3'd7 ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
          '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_id <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      illegal <= 1'b0;
      ptr <= 1'b0;
    end else if (acc) begin
      resp_valid <= 1'b1;
      resp_id <= sel;
      result <= res;
      zero <= res == '0;
      illegal <= ill;
      ptr <= !sel;
    end else if (bus.resp_ready)
      resp_valid <= 1'b0;
  assign bus.req0_ready = slot_free && g0;
  assign bus.req1_ready = slot_free && g1;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_id = resp_id;
  assign bus.result = result;
  assign bus.zero = zero;
  assign bus.illegal = illegal;
endmodule
